// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// frame-length decoding and the default inter-byte timeout.
package loader_pkg;

    typedef enum logic [2:0] {
        WAIT_LEN,
        DATA_HI,
        DATA_LO,
        CHECK,
        RUN,
        ERROR
    } loader_state_t;

    localparam logic [8:0]  LEN_ZERO_MEANS         = 9'd256;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // A LEN byte of zero encodes a full 256-instruction image.
    function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? LEN_ZERO_MEANS : {1'b0, len_byte};
    endfunction

    // States in which a frame is in flight and the idle timer runs.
    function automatic logic is_busy_state(input loader_state_t s);
        return (s == DATA_HI) || (s == DATA_LO) || (s == CHECK);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: restarts on clear, counts while enabled, and flags
// expiry on the cycle whose clock edge would complete TIMEOUT_CYCLES idle clocks.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Combinational in count_q/enable only, so the FSM can use it without a loop through clear.
    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image byte-by-byte, writes 16-bit instructions into
// the CPU ICache and releases the CPU from reset once the XOR checksum matches.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        load_request,
    output logic        cpu_reset,
    output logic [7:0]  write_instruction_index,
    output logic [15:0] write_instruction,
    output logic        write_strobe,
    output logic        busy,
    output logic        error
);

    loader_state_t state_q, state_d;

    logic [8:0]  n_q,      n_d;
    logic [8:0]  cnt_q,    cnt_d;
    logic [7:0]  chk_q,    chk_d;
    logic [7:0]  hold_q,   hold_d;
    logic [7:0]  idx_q,    idx_d;
    logic [15:0] instr_q,  instr_d;
    logic        strobe_q, strobe_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q,   busy_d;
    logic        error_q,  error_d;

    logic accept;
    logic last_word;
    logic timeout_clear;
    logic timeout_enable;
    logic timeout_expired;

    // load_request wins over a coincident byte, which is dropped.
    assign accept    = rx_valid && !load_request;
    assign last_word = (cnt_q + 9'd1) == n_q;

    assign timeout_enable = is_busy_state(state_q);
    assign timeout_clear  = load_request || accept || (state_d != state_q);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timeout_clear),
        .enable (timeout_enable),
        .expired(timeout_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (load_request) begin
            state_d = WAIT_LEN;
        end else begin
            case (state_q)
                WAIT_LEN, ERROR: begin
                    if (accept) state_d = DATA_HI;
                end
                DATA_HI: begin
                    if (accept)               state_d = DATA_LO;
                    else if (timeout_expired) state_d = ERROR;
                end
                DATA_LO: begin
                    if (accept)               state_d = last_word ? CHECK : DATA_HI;
                    else if (timeout_expired) state_d = ERROR;
                end
                CHECK: begin
                    if (accept)               state_d = (rx_byte == chk_q) ? RUN : ERROR;
                    else if (timeout_expired) state_d = ERROR;
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WAIT_LEN;
                end
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        n_d      = n_q;
        cnt_d    = cnt_q;
        chk_d    = chk_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        instr_d  = instr_q;
        strobe_d = 1'b0;

        if (accept) begin
            case (state_q)
                WAIT_LEN, ERROR: begin
                    n_d   = decode_len(rx_byte);
                    cnt_d = '0;
                    chk_d = '0;
                end
                DATA_HI: begin
                    hold_d = rx_byte;
                    chk_d  = chk_q ^ rx_byte;
                end
                DATA_LO: begin
                    instr_d  = {hold_q, rx_byte};
                    idx_d    = cnt_q[7:0];
                    strobe_d = 1'b1;
                    chk_d    = chk_q ^ rx_byte;
                    cnt_d    = cnt_q + 9'd1;
                end
                default: begin
                end
            endcase
        end

        cpu_rst_d = (state_d != RUN);
        busy_d    = is_busy_state(state_d);

        // Sticky error: cleared when a new frame begins, set on entering ERROR.
        error_d = error_q;
        if (load_request) begin
            error_d = 1'b0;
        end else if (accept && (state_q == WAIT_LEN || state_q == ERROR)) begin
            error_d = 1'b0;
        end else if (state_d == ERROR) begin
            error_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q       <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            instr_q   <= '0;
            strobe_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            instr_q   <= instr_d;
            strobe_q  <= strobe_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign cpu_reset               = cpu_rst_q;
    assign write_instruction_index = idx_q;
    assign write_instruction       = instr_q;
    assign write_strobe            = strobe_q;
    assign busy                    = busy_q;
    assign error                   = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a short timeout; each task drives one
// scenario and compares outputs against hand-computed values.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        load_request;
    logic        cpu_reset;
    logic [7:0]  write_instruction_index;
    logic [15:0] write_instruction;
    logic        write_strobe;
    logic        busy;
    logic        error;

    int errors = 0;
    int checks = 0;

    int          wr_count    = 0;
    int          zero_writes = 0;
    logic [15:0] mem [256];

    program_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .rx_valid               (rx_valid),
        .rx_byte                (rx_byte),
        .load_request           (load_request),
        .cpu_reset              (cpu_reset),
        .write_instruction_index(write_instruction_index),
        .write_instruction      (write_instruction),
        .write_strobe           (write_strobe),
        .busy                   (busy),
        .error                  (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_strobe === 1'b1) begin
            wr_count++;
            if (write_instruction_index == 8'h00) zero_writes++;
            mem[write_instruction_index] = write_instruction;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_request = 1'b1;
        @(posedge clk);
        #1;
        load_request = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_byte      = 8'h00;
        load_request = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (write_instruction_index !== 8'h00) begin errors++; $display("FAIL reset_index: got %h want 00", write_instruction_index); end
        checks++; if (write_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", write_instruction); end
        checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", write_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        int w0;
        w0 = wr_count;
        send_byte(8'h02);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_len: got %b want 1", busy); end
        send_byte(8'hAA);
        send_byte(8'hBB);
        checks++; if (write_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe0: got %b want 1", write_strobe); end
        checks++; if (write_instruction_index !== 8'h00) begin errors++; $display("FAIL basic_idx0: got %h want 00", write_instruction_index); end
        checks++; if (write_instruction !== 16'hAABB) begin errors++; $display("FAIL basic_data0: got %h want AABB", write_instruction); end
        send_byte(8'hCC);
        checks++; if (write_strobe !== 1'b0) begin errors++; $display("FAIL basic_strobe_drop: got %b want 0", write_strobe); end
        checks++; if (write_instruction !== 16'hAABB) begin errors++; $display("FAIL basic_data_hold: got %h want AABB", write_instruction); end
        send_byte(8'hDD);
        checks++; if (write_instruction_index !== 8'h01) begin errors++; $display("FAIL basic_idx1: got %h want 01", write_instruction_index); end
        checks++; if (write_instruction !== 16'hCCDD) begin errors++; $display("FAIL basic_data1: got %h want CCDD", write_instruction); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_held_before_chk: got %b want 1", cpu_reset); end
        send_byte(8'h00);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_release: got %b want 0", cpu_reset); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_run: got %b want 0", busy); end
        checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", wr_count - w0); end
    endtask

    task automatic test_load_request();
        rx_byte      = 8'h05;
        rx_valid     = 1'b1;
        load_request = 1'b1;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        load_request = 1'b0;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ldreq_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ldreq_byte_dropped: busy got %b want 0", busy); end
        send_byte(8'h01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ldreq_len_busy: got %b want 1", busy); end
        send_byte(8'h12);
        send_byte(8'h34);
        checks++; if (write_instruction !== 16'h1234 || write_instruction_index !== 8'h00 || write_strobe !== 1'b1) begin
            errors++; $display("FAIL ldreq_write: got idx %h data %h strobe %b want 00 1234 1", write_instruction_index, write_instruction, write_strobe);
        end
        send_byte(8'h26);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL ldreq_run: got %b want 0", cpu_reset); end
    endtask

    task automatic test_bad_checksum();
        pulse_load();
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'h01);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badchk_error: got %b want 1", error); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL badchk_held: got %b want 1", cpu_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badchk_busy: got %b want 0", busy); end
        send_byte(8'h01);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL badchk_error_clear: got %b want 0", error); end
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h33);
        checks++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL badchk_recover: got cpu_reset %b error %b want 0 0", cpu_reset, error);
        end
    endtask

    task automatic test_len256();
        int w0;
        int z0;
        pulse_load();
        w0 = wr_count;
        z0 = zero_writes;
        send_byte(8'h00);
        for (int j = 0; j < 512; j++) begin
            send_byte(j[7:0]);
        end
        checks++; if (write_instruction_index !== 8'hFF || write_instruction !== 16'hFEFF) begin
            errors++; $display("FAIL len256_last: got idx %h data %h want FF FEFF", write_instruction_index, write_instruction);
        end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL len256_held: got %b want 1", cpu_reset); end
        send_byte(8'h00);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL len256_run: got %b want 0", cpu_reset); end
        checks++; if (wr_count - w0 !== 256) begin errors++; $display("FAIL len256_count: got %0d want 256", wr_count - w0); end
        checks++; if (zero_writes - z0 !== 1) begin errors++; $display("FAIL len256_idx0_writes: got %0d want 1", zero_writes - z0); end
        checks++; if (mem[8'h05] !== 16'h0A0B) begin errors++; $display("FAIL len256_mem05: got %h want 0A0B", mem[8'h05]); end
        checks++; if (mem[8'h80] !== 16'h0001) begin errors++; $display("FAIL len256_mem80: got %h want 0001", mem[8'h80]); end
    endtask

    task automatic test_timeout();
        int early;
        pulse_load();
        send_byte(8'h01);
        send_byte(8'hAA);
        early = 0;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (error !== 1'b0 || busy !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
        @(posedge clk);
        #1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL timeout_held: got %b want 1", cpu_reset); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h01);
        send_byte(8'h77);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || write_strobe !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: got cpu_reset %b busy %b error %b strobe %b want 1 0 0 0", cpu_reset, busy, error, write_strobe);
        end
        checks++; if (write_instruction_index !== 8'h00 || write_instruction !== 16'h0000) begin
            errors++; $display("FAIL midreset_data: got idx %h data %h want 00 0000", write_instruction_index, write_instruction);
        end
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h9A);
        send_byte(8'hBC);
        checks++; if (write_strobe !== 1'b1 || write_instruction_index !== 8'h00 || write_instruction !== 16'h9ABC) begin
            errors++; $display("FAIL midreset_reload: got strobe %b idx %h data %h want 1 00 9ABC", write_strobe, write_instruction_index, write_instruction);
        end
        send_byte(8'h26);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL midreset_run: got %b want 0", cpu_reset); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_load_request();
        test_bad_checksum();
        test_len256();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the CPU top: receives a framed program image as a byte stream from a UART receiver. It assembles bytes into 16-bit instructions and drives the CPU's `write_instruction_index` / `write_instruction` pins. It holds the CPU in reset until the whole frame has loaded and its XOR checksum matches, then releases the CPU to run from its reset index.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: max idle clocks between bytes inside a frame before abort.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; returns block to WAIT_LEN.
- `rx_valid`  in  1  single-cycle strobe, `rx_byte` valid.
- `rx_byte`  in  8  received byte.
- `load_request`  in  1  pulse; aborts/halts CPU and starts a new frame.
- `cpu_reset`  out  1  drives CPU `reset`; high = CPU held, ICache writable.
- `write_instruction_index`  out  8  ICache write index.
- `write_instruction`  out  16  ICache write data, raw memory byte order.
- `write_strobe`  out  1  one-cycle pulse per instruction written (for debug/verification; ICache writes continuously while `cpu_reset` high).
- `busy`  out  1  high in DATA_HI, DATA_LO, CHECK.
- `error`  out  1  sticky until next frame starts; checksum mismatch or timeout.

## Operation
- Frame: LEN, then 2×N data bytes, then CHK. N = LEN, with LEN = 0 meaning N = 256. CHK = XOR of all 2N data bytes (LEN excluded).
- States: WAIT_LEN, DATA_HI, DATA_LO, CHECK, RUN, ERROR.
- WAIT_LEN: byte accepted → latch N, clear checksum, clear `error`, index counter := 0, → DATA_HI.
- DATA_HI: byte → hold register, checksum ^= byte, → DATA_LO.
- DATA_LO: byte → `write_instruction` = {hold, byte} (first byte in [15:8]; the CPU's endian inverter swaps later). `write_instruction_index` = counter; `write_strobe`; checksum ^= byte; counter++.
  - If counter (9-bit) reaches N → CHECK, else → DATA_HI.
- CHECK: byte == checksum → RUN; otherwise → ERROR with `error` := 1.
- RUN: `cpu_reset` = 0. `rx_valid` ignored.
- ERROR: `cpu_reset` = 1. The next accepted byte is treated as LEN (same as WAIT_LEN).
- `load_request` in any state → WAIT_LEN, `cpu_reset` = 1, `error` cleared. It has priority over a coincident `rx_valid`; that byte is discarded.
- Timeout: counter cleared on every accepted byte and on state entry; increments only in DATA_HI/DATA_LO/CHECK. On reaching `TIMEOUT_CYCLES` → ERROR, `error` := 1. Instructions already written stay in ICache; the CPU stays held.
- Index counter is 9 bits internally; output is the low 8 bits. N = 256 writes indices 0..255 with no wrap past 255.

## Timing
- Reset values:
  - `cpu_reset` = 1
  - `write_instruction_index` = 0, `write_instruction` = 0
  - `write_strobe` = 0, `busy` = 0, `error` = 0
  - state WAIT_LEN
- All outputs registered. Byte accepted at edge k → state/outputs updated after edge k.
- `write_strobe` high exactly one cycle after the DATA_LO byte edge. Index/data change in that same cycle and hold until the next write.
- `cpu_reset` falls one cycle after the matching CHK byte. It rises one cycle after `load_request`, timeout expiry, or `reset` (immediately, since `reset` is asynchronous).
- Back-to-back `rx_valid` on consecutive cycles is supported; no backpressure exists.
- `reset` mid-frame: immediate WAIT_LEN, partial frame discarded, `cpu_reset` high.

## Structure
- `loader_pkg`: state enum `loader_state_t`, `LEN_ZERO_MEANS = 9'd256`, default timeout constant.
- One sub-module, `loader_timeout`: parameterised counter with `clear`, `enable`, and `expired` output. Everything else lives in `program_loader`.

## Test plan
- Frame 02, AA,BB, CC,DD, CHK=AA^BB^CC^DD=00 → writes idx0=AABB, idx1=CCDD, two strobes, `cpu_reset` falls one cycle after CHK, `error`=0.
- Same frame with CHK=01 → state ERROR, `error`=1, `cpu_reset` stays 1. A following valid frame clears `error` and reaches RUN.
- LEN=00, 512 bytes of incrementing pattern → 256 writes, last index FF, no write to index 0 after the first, correct checksum → RUN.
- TIMEOUT_CYCLES=16: LEN=01, one data byte, then silence → `error`=1 exactly 16 cycles after the last byte, `busy`=0.
- In RUN, `load_request` coincident with `rx_valid`=1 byte 05 → `cpu_reset`=1 next cycle, byte 05 not taken as LEN. Next byte 01 starts a 1-instruction frame.
- Assert `reset` between DATA_HI and DATA_LO → all outputs return to reset values asynchronously. The subsequent complete frame loads from idx 0.
